// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the 16-bit 5-stage CPU pipeline control
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1
    } ctrl_state_t;

    localparam int REG_ADDR_W    = 4;
    localparam int MULDIV_CYCLES = 8;

endpackage

// File: rtl/stall_counter.sv
// stall_counter: saturating event counter with async active-low clear
//   clk    in  clock, rising edge
//   clr_n  in  asynchronous clear, active-low
//   inc    in  count this cycle
//   count  out current value, sticks at all-ones
module stall_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: IF/ID/EX stall, flush and mul/div sequencing for the 5-stage CPU
//   clk, reset (async, active-low)
//   ifid_valid/ifid_rs/ifid_rt     instruction in ID and its sources
//   idex_memread/idex_rd/idex_muldiv/branch_taken   instruction in EX
//   pc_write/ifid_write/ifid_flush/idex_flush/ex_hold/exm_bubble   pipeline controls
//   alu_start/alu_done             mul/div handshake pulses to the ALU
//   ctrl_state                     FSM state (debug)
//   stall_cycles                   saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W    = cpu_pkg::REG_ADDR_W,
    parameter int MULDIV_CYCLES = cpu_pkg::MULDIV_CYCLES,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ifid_valid,
    input  logic [REG_ADDR_W-1:0]  ifid_rs,
    input  logic [REG_ADDR_W-1:0]  ifid_rt,
    input  logic                   idex_memread,
    input  logic [REG_ADDR_W-1:0]  idex_rd,
    input  logic                   idex_muldiv,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   ex_hold,
    output logic                   exm_bubble,
    output logic                   alu_start,
    output logic                   alu_done,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    import cpu_pkg::*;

    // The start cycle happens in RUN and the release cycle at cnt==0,
    // so the down-counter only covers the cycles in between.
    localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 2);

    ctrl_state_t state;
    logic [3:0]  cnt;
    logic        load_use;

    assign load_use   = idex_memread && ifid_valid && (idex_rd == ifid_rs || idex_rd == ifid_rt);
    assign ctrl_state = state;

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        ex_hold    = 1'b0;
        exm_bubble = 1'b0;
        alu_start  = 1'b0;
        alu_done   = 1'b0;
        if (!reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state == MULDIV) begin
            // Branch and load-use are ignored here: EX is occupied by the mul/div op.
            if (cnt != 4'd0) begin
                ex_hold    = 1'b1;
                exm_bubble = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else begin
                alu_done = 1'b1;
            end
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (idex_muldiv) begin
            alu_start  = 1'b1;
            ex_hold    = 1'b1;
            exm_bubble = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else if (state == MULDIV) begin
            if (cnt == 4'd0)
                state <= RUN;
            else
                cnt <= cnt - 4'd1;
        end else if (!branch_taken && idex_muldiv) begin
            state <= MULDIV;
            cnt   <= CNT_INIT;
        end
    end

    stall_counter #(.W(STALL_CNT_W)) u_stall_counter (
        .clk   (clk),
        .clr_n (reset),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard, branch, mul/div and counter behaviour
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifid_valid;
    logic [3:0]  ifid_rs, ifid_rt, idex_rd;
    logic        idex_memread, idex_muldiv, branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic        ex_hold, exm_bubble, alu_start, alu_done;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush;
    logic        s_ex_hold, s_exm_bubble, s_alu_start, s_alu_done;
    logic [1:0]  s_ctrl_state;
    logic [3:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .idex_muldiv(idex_muldiv),
        .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .ex_hold(ex_hold),
        .exm_bubble(exm_bubble), .alu_start(alu_start), .alu_done(alu_done),
        .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .idex_muldiv(idex_muldiv),
        .branch_taken(branch_taken), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .ex_hold(s_ex_hold),
        .exm_bubble(s_exm_bubble), .alu_start(s_alu_start), .alu_done(s_alu_done),
        .ctrl_state(s_ctrl_state), .stall_cycles(s_stall_cycles)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_valid   = 1'b0;
        ifid_rs      = 4'h0;
        ifid_rt      = 4'h0;
        idex_memread = 1'b0;
        idex_rd      = 4'h0;
        idex_muldiv  = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #2;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write: got %b want 0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL rst_ifid_write: got %b want 0", ifid_write); end
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL rst_ifid_flush: got %b want 1", ifid_flush); end
        checks++; if (idex_flush !== 1'b1) begin errors++; $display("FAIL rst_idex_flush: got %b want 1", idex_flush); end
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", ctrl_state); end
        checks++; if ({ex_hold, exm_bubble, alu_start, alu_done} !== 4'b0) begin errors++; $display("FAIL rst_misc: got %b want 0000", {ex_hold, exm_bubble, alu_start, alu_done}); end
        cyc();
        cyc();
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
        reset = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_flush !== 1'b0) begin errors++; $display("FAIL rst_release: got pc_write=%b ifid_flush=%b want 1/0", pc_write, ifid_flush); end
        exp_stall = 0;
    endtask

    task automatic test_load_use();
        cyc();
        idex_memread = 1'b1; idex_rd = 4'h3; ifid_rs = 4'h3; ifid_rt = 4'h5; ifid_valid = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write: got %b want 0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write: got %b want 0", ifid_write); end
        checks++; if (idex_flush !== 1'b1) begin errors++; $display("FAIL lu_idex_flush: got %b want 1", idex_flush); end
        checks++; if (ifid_flush !== 1'b0 || ex_hold !== 1'b0) begin errors++; $display("FAIL lu_other: got ifid_flush=%b ex_hold=%b want 0/0", ifid_flush, ex_hold); end
        cyc();
        idle();
        #1;
        exp_stall += 1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release: got %b want 1", pc_write); end
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL lu_stall: got %0d want %0d", stall_cycles, exp_stall); end
        idex_memread = 1'b1; idex_rd = 4'h3; ifid_rs = 4'h3; ifid_valid = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin errors++; $display("FAIL lu_invalid: got pc_write=%b idex_flush=%b want 1/0", pc_write, idex_flush); end
        cyc();
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL lu_invalid_stall: got %0d want %0d", stall_cycles, exp_stall); end
        idex_rd = 4'h2; ifid_rs = 4'h3; ifid_rt = 4'h4; ifid_valid = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_nomatch: got %b want 1", pc_write); end
        idex_rd = 4'h0; ifid_rs = 4'h7; ifid_rt = 4'h0;
        #1;
        checks++; if (pc_write !== 1'b0 || idex_flush !== 1'b1) begin errors++; $display("FAIL lu_r0_rt: got pc_write=%b idex_flush=%b want 0/1", pc_write, idex_flush); end
        cyc();
        idle();
        #1;
        exp_stall += 1;
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL lu_r0_stall: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_muldiv();
        cyc();
        idex_muldiv = 1'b1;
        #1;
        checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL md_start: got %b want 1", alu_start); end
        checks++; if ({ex_hold, exm_bubble, pc_write, ifid_write} !== 4'b1100) begin errors++; $display("FAIL md_c0: got %b want 1100", {ex_hold, exm_bubble, pc_write, ifid_write}); end
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL md_c0_state: got %0d want 0", ctrl_state); end
        for (int i = 1; i <= 6; i++) begin
            cyc();
            checks++; if ({ex_hold, exm_bubble, pc_write, alu_start, alu_done} !== 5'b11000 || ctrl_state !== 2'd1) begin
                errors++; $display("FAIL md_c%0d: got %b state %0d want 11000 state 1", i, {ex_hold, exm_bubble, pc_write, alu_start, alu_done}, ctrl_state);
            end
        end
        cyc();
        checks++; if (alu_done !== 1'b1) begin errors++; $display("FAIL md_done: got %b want 1", alu_done); end
        checks++; if ({pc_write, ifid_write, ex_hold, exm_bubble} !== 4'b1100) begin errors++; $display("FAIL md_release: got %b want 1100", {pc_write, ifid_write, ex_hold, exm_bubble}); end
        idex_muldiv = 1'b0;
        cyc();
        exp_stall += 7;
        checks++; if (ctrl_state !== 2'd0 || alu_done !== 1'b0) begin errors++; $display("FAIL md_after: got state %0d done %b want 0/0", ctrl_state, alu_done); end
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL md_stall: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_priority();
        cyc();
        branch_taken = 1'b1; idex_memread = 1'b1; idex_rd = 4'h6; ifid_rs = 4'h6; ifid_valid = 1'b1;
        #1;
        checks++; if ({ifid_flush, idex_flush, pc_write, ifid_write} !== 4'b1111) begin errors++; $display("FAIL pri_br_lu: got %b want 1111", {ifid_flush, idex_flush, pc_write, ifid_write}); end
        cyc();
        idle();
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL pri_br_stall: got %0d want %0d", stall_cycles, exp_stall); end
        branch_taken = 1'b1; idex_muldiv = 1'b1;
        #1;
        checks++; if ({alu_start, ex_hold, pc_write} !== 3'b001) begin errors++; $display("FAIL pri_br_md: got %b want 001", {alu_start, ex_hold, pc_write}); end
        cyc();
        idle();
        #1;
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL pri_br_md_state: got %0d want 0", ctrl_state); end
        cyc();
        idex_muldiv = 1'b1;
        #1;
        checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL pri_md_start: got %b want 1", alu_start); end
        cyc();
        cyc();
        branch_taken = 1'b1; idex_memread = 1'b1; idex_rd = 4'h6; ifid_rs = 4'h6; ifid_valid = 1'b1;
        #1;
        checks++; if ({ex_hold, ifid_flush, idex_flush, pc_write} !== 4'b1000 || ctrl_state !== 2'd1) begin
            errors++; $display("FAIL pri_md_branch: got %b state %0d want 1000 state 1", {ex_hold, ifid_flush, idex_flush, pc_write}, ctrl_state);
        end
        for (int i = 3; i <= 6; i++) cyc();
        cyc();
        checks++; if (alu_done !== 1'b1 || ifid_flush !== 1'b0) begin errors++; $display("FAIL pri_md_done: got done=%b ifid_flush=%b want 1/0", alu_done, ifid_flush); end
        idle();
        cyc();
        exp_stall += 7;
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL pri_md_stall: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_back_to_back();
        cyc();
        idex_muldiv = 1'b1;
        #1;
        checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL b2b_start1: got %b want 1", alu_start); end
        repeat (6) cyc();
        cyc();
        checks++; if (alu_done !== 1'b1 || alu_start !== 1'b0) begin errors++; $display("FAIL b2b_done1: got done=%b start=%b want 1/0", alu_done, alu_start); end
        cyc();
        checks++; if ({alu_start, alu_done, ex_hold} !== 3'b101 || ctrl_state !== 2'd0) begin
            errors++; $display("FAIL b2b_start2: got %b state %0d want 101 state 0", {alu_start, alu_done, ex_hold}, ctrl_state);
        end
        repeat (6) cyc();
        cyc();
        checks++; if (alu_done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", alu_done); end
        idle();
        cyc();
        exp_stall += 14;
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL b2b_stall: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_reset_mid_muldiv();
        int early;
        cyc();
        idex_muldiv = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        exp_stall = 0;
        checks++; if (ctrl_state !== 2'd0 || alu_done !== 1'b0) begin errors++; $display("FAIL rmd_abort: got state %0d done %b want 0/0", ctrl_state, alu_done); end
        checks++; if ({pc_write, ifid_flush, idex_flush} !== 3'b011) begin errors++; $display("FAIL rmd_forced: got %b want 011", {pc_write, ifid_flush, idex_flush}); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rmd_stall_clr: got %0d want 0", stall_cycles); end
        cyc();
        idle();
        reset = 1'b1;
        #1;
        checks++; if (ctrl_state !== 2'd0 || alu_done !== 1'b0 || pc_write !== 1'b1) begin
            errors++; $display("FAIL rmd_release: got state %0d done %b pc_write %b want 0/0/1", ctrl_state, alu_done, pc_write);
        end
        cyc();
        idex_muldiv = 1'b1;
        #1;
        checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL rmd_restart: got %b want 1", alu_start); end
        early = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (alu_done !== 1'b0 || ex_hold !== 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL rmd_full_hold: got %0d bad cycles want 0", early); end
        cyc();
        checks++; if (alu_done !== 1'b1) begin errors++; $display("FAIL rmd_done: got %b want 1", alu_done); end
        idle();
        cyc();
        exp_stall += 7;
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL rmd_stall: got %0d want %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_saturation();
        cyc();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        exp_stall = 0;
        checks++; if (s_stall_cycles !== 4'h0) begin errors++; $display("FAIL sat_clr: got %h want 0", s_stall_cycles); end
        idex_memread = 1'b1; idex_rd = 4'h9; ifid_rt = 4'h9; ifid_valid = 1'b1;
        repeat (14) cyc();
        checks++; if (s_stall_cycles !== 4'hE) begin errors++; $display("FAIL sat_14: got %h want e", s_stall_cycles); end
        cyc();
        checks++; if (s_stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_15: got %h want f", s_stall_cycles); end
        repeat (5) cyc();
        exp_stall = 20;
        checks++; if (s_stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_20: got %h want f", s_stall_cycles); end
        checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL sat_wide: got %0d want %0d", stall_cycles, exp_stall); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_priority();
        test_back_to_back();
        test_reset_mid_muldiv();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
